uc_dispara_tiro: RTL

Shot-spawning control unit with its own slot counter and cooldown timer. It is the writer side of the shot memory whose entries the shot/asteroid comparison unit clears. On a fire request it scans the shot memory for the first slot whose `loaded` bit is 0. It then writes a new shot there (ship position, direction, `loaded` = 1) and enforces a refire cooldown. While it is not idle it raises `ocupado`, and top level holds off the comparison start until `ocupado` is low, so the two units never access the shot memory at the same time.

---
 rtl/uc_dispara_tiro_if.sv | 32 +++
 rtl/uc_dispara_tiro.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uc_dispara_tiro_if.sv
// Shot memory bus between the shot-spawning control unit (master) and
// the shot memory (slave). The memory answers mem_tiro_loaded
// combinationally for the address currently on endereco_tiro.
interface uc_dispara_tiro_if #(
    parameter int ADDR_W = 4,
    parameter int POS_W  = 8
);
    logic [ADDR_W-1:0] endereco_tiro;
    logic              enable_mem_tiro;
    logic [POS_W-1:0]  dado_posicao;
    logic [1:0]        dado_direcao;
    logic              dado_loaded;
    logic              mem_tiro_loaded;

    modport master (
        output endereco_tiro,
        output enable_mem_tiro,
        output dado_posicao,
        output dado_direcao,
        output dado_loaded,
        input  mem_tiro_loaded
    );

    modport slave (
        input  endereco_tiro,
        input  enable_mem_tiro,
        input  dado_posicao,
        input  dado_direcao,
        input  dado_loaded,
        output mem_tiro_loaded
    );
endinterface

// File: rtl/uc_dispara_tiro.sv
// Shot-spawning control unit. On a fire request it scans the shot memory
// for the lowest slot whose loaded bit is clear, writes the captured ship
// position/direction there and then waits out a refire cooldown. ocupado
// is high whenever the unit may be touching the shot memory, so the
// comparison unit can be held off until it drops.
module uc_dispara_tiro #(
    parameter int N_TIROS  = 16,
    parameter int ADDR_W   = 4,
    parameter int POS_W    = 8,
    parameter int COOLDOWN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dispara,
    input  logic [POS_W-1:0]  posicao_nave,
    input  logic [1:0]        direcao_nave,
    uc_dispara_tiro_if.master mem,
    output logic              tiro_disparado,
    output logic              sem_slot,
    output logic              ocupado,
    output logic [4:0]        db_estado
);

    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    typedef enum logic [4:0] {
        st_inicio          = 5'h00,
        st_espera          = 5'h01,
        st_reseta_contador = 5'h02,
        st_verifica_slot   = 5'h03,
        st_incrementa      = 5'h04,
        st_grava_tiro      = 5'h05,
        st_tiro_ok         = 5'h06,
        st_sem_espaco      = 5'h07,
        st_recarga         = 5'h08,
        st_erro            = 5'h0F
    } estado_t;

    estado_t           estado;
    estado_t           proximo;
    logic [ADDR_W-1:0] contador_slot;
    logic [CD_W-1:0]   contador_recarga;
    logic [POS_W-1:0]  posicao_q;
    logic [1:0]        direcao_q;

    // The slot address is the scan counter itself, and the written entry
    // is always the data captured when the request was accepted.
    assign mem.endereco_tiro = contador_slot;
    assign mem.dado_posicao  = posicao_q;
    assign mem.dado_direcao  = direcao_q;
    assign mem.dado_loaded   = 1'b1;

    // State register; reset aborts any scan or write in progress at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= st_inicio;
        end else begin
            estado <= proximo;
        end
    end

    // Slot counter, cooldown counter and request data capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador_slot    <= '0;
            contador_recarga <= '0;
            posicao_q        <= '0;
            direcao_q        <= '0;
        end else begin
            if (estado == st_espera && dispara) begin
                posicao_q <= posicao_nave;
                direcao_q <= direcao_nave;
            end
            if (estado == st_reseta_contador) begin
                contador_slot <= '0;
            end else if (estado == st_incrementa) begin
                contador_slot <= contador_slot + ADDR_W'(1);
            end
            if (estado == st_tiro_ok) begin
                contador_recarga <= CD_W'(COOLDOWN);
            end else if (estado == st_recarga) begin
                contador_recarga <= contador_recarga - CD_W'(1);
            end
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        proximo             = st_inicio;
        mem.enable_mem_tiro = 1'b0;
        tiro_disparado      = 1'b0;
        sem_slot            = 1'b0;
        ocupado             = 1'b1;
        db_estado           = estado;
        case (estado)
            st_inicio: begin
                ocupado = 1'b0;
                proximo = st_espera;
            end
            st_espera: begin
                ocupado = 1'b0;
                proximo = dispara ? st_reseta_contador : st_espera;
            end
            st_reseta_contador: begin
                proximo = st_verifica_slot;
            end
            st_verifica_slot: begin
                if (!mem.mem_tiro_loaded) begin
                    proximo = st_grava_tiro;
                end else if (contador_slot == ADDR_W'(N_TIROS - 1)) begin
                    proximo = st_sem_espaco;
                end else begin
                    proximo = st_incrementa;
                end
            end
            st_incrementa: begin
                proximo = st_verifica_slot;
            end
            st_grava_tiro: begin
                mem.enable_mem_tiro = 1'b1;
                proximo             = st_tiro_ok;
            end
            st_tiro_ok: begin
                tiro_disparado = 1'b1;
                proximo        = st_recarga;
            end
            st_sem_espaco: begin
                sem_slot = 1'b1;
                proximo  = st_espera;
            end
            st_recarga: begin
                proximo = (contador_recarga <= CD_W'(1)) ? st_espera : st_recarga;
            end
            default: begin
                proximo = st_inicio;
            end
        endcase
    end

endmodule
